vc_sched: RTL and testbench

VC_SCHED -- requirements
Module: vc_sched

---
 rtl/vc_sched_pkg.sv | 15 +
 rtl/vc_sched_rr_arbiter.sv | 29 ++
 rtl/vc_sched.sv | 109 ++++++++++
 tb/tb_vc_sched.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vc_sched_pkg.sv
// Shared definitions for the virtual-channel scheduler: FSM encodings and size defaults.
package vc_sched_pkg;

    localparam int NUM_VC_DEF = 4;
    localparam int TH_W_DEF   = 5;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/vc_sched_rr_arbiter.sv
// Four-way rotating-priority arbiter: grants the first requester at or after ptr, wrapping modulo 4.
module rr_arbiter
    import vc_sched_pkg::*;
(
    input  logic [3:0] request,
    input  logic [1:0] pointer,
    output logic [3:0] grant,
    output logic [1:0] grant_idx
);

    logic [1:0] cand;
    logic       found;

    always_comb begin
        grant     = '0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        found     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = pointer + 2'(k);
            if (!found && request[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/vc_sched.sv
// VC FIFO scheduler: control FSM, threshold latches and the one-cycle pop-to-push pipeline.
// Build option VC_SCHED_STRICT_PRIO_EN selects fixed priority (VC0 highest) instead of round-robin.
module vc_sched
    import vc_sched_pkg::*;
#(
    parameter int NUM_VC = NUM_VC_DEF,
    parameter int TH_W   = TH_W_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              init,
    input  logic [TH_W-1:0]   afull_th_in,
    input  logic [TH_W-1:0]   aempty_th_in,
    input  logic [NUM_VC-1:0] empty,
    input  logic              out_afull,
    input  logic [NUM_VC:0]   fifo_err,
    output logic [NUM_VC-1:0] pop,
    output logic              push_out,
    output logic [1:0]        sel,
    output logic [TH_W-1:0]   afull_th,
    output logic [TH_W-1:0]   aempty_th,
    output logic              idle,
    output logic              active,
    output logic              error,
    output logic [2:0]        state
);

    state_t      state_q, state_d;
    logic [3:0]  gnt;
    logic [1:0]  gnt_idx;
    logic        any_err;
    logic        granted;
    logic [1:0]  arb_ptr;

    assign any_err = |fifo_err;

`ifdef VC_SCHED_STRICT_PRIO_EN
    assign arb_ptr = 2'd0;
`else
    logic [1:0] rr_ptr;
    assign arb_ptr = rr_ptr;
`endif

    rr_arbiter u_arb (
        .request   (~empty),
        .pointer   (arb_ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    // Pops are gated the same cycle out_afull rises; ERROR is covered by the state test.
    assign pop     = (state_q == ST_ACTIVE && !out_afull) ? gnt : '0;
    assign granted = |pop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = any_err ? ST_ERROR : (init ? ST_INIT : ST_IDLE);
            ST_IDLE: begin
                if (any_err)     state_d = ST_ERROR;
                else if (init)   state_d = ST_INIT;
                else if (~&empty) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (any_err)     state_d = ST_ERROR;
                else if (init)   state_d = ST_INIT;
                else if (&empty) state_d = ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    // Pop stage to push stage: push_out/sel trail the pop by one cycle, independent of state.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            push_out  <= 1'b0;
            sel       <= 2'd0;
            afull_th  <= '0;
            aempty_th <= '0;
        end else begin
            push_out <= granted;
            if (granted) sel <= gnt_idx;
            if (state_q == ST_INIT && init) begin
                afull_th  <= afull_th_in;
                aempty_th <= aempty_th_in;
            end
        end
    end

`ifndef VC_SCHED_STRICT_PRIO_EN
    always_ff @(posedge CLK) begin
        if (!reset)       rr_ptr <= 2'd0;
        else if (granted) rr_ptr <= gnt_idx + 2'd1;
    end
`endif

    assign idle   = (state_q == ST_IDLE);
    assign active = (state_q == ST_ACTIVE);
    assign error  = (state_q == ST_ERROR);
    assign state  = state_q;

endmodule

// File: tb/tb_vc_sched.sv
// Directed bench for vc_sched with a scoreboard queue pairing each pop with its delayed push_out/sel.
module tb_vc_sched;

`ifdef VC_SCHED_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       reset, init, out_afull;
    logic [4:0] afull_th_in, aempty_th_in;
    logic [3:0] empty;
    logic [4:0] fifo_err;
    logic [3:0] pop;
    logic       push_out;
    logic [1:0] sel;
    logic [4:0] afull_th, aempty_th;
    logic       idle, active, error;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       push;
        logic [1:0] sel;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    vc_sched dut (
        .CLK          (CLK),
        .reset        (reset),
        .init         (init),
        .afull_th_in  (afull_th_in),
        .aempty_th_in (aempty_th_in),
        .empty        (empty),
        .out_afull    (out_afull),
        .fifo_err     (fifo_err),
        .pop          (pop),
        .push_out     (push_out),
        .sel          (sel),
        .afull_th     (afull_th),
        .aempty_th    (aempty_th),
        .idle         (idle),
        .active       (active),
        .error        (error),
        .state        (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // rr_exp is the round-robin expectation; in strict builds a nonzero expectation becomes lowest non-empty VC.
    task automatic step(input logic [3:0] rr_exp, input string tag);
        logic [3:0] e;
        logic [3:0] req;
        exp_t       ent;
        #1;
        req = ~empty;
        e = (rr_exp == 4'b0) ? 4'b0 : (STRICT ? (req & (~req + 4'd1)) : rr_exp);
        chk({tag, "_pop"}, 32'(pop), 32'(e));
        sb.push_back('{push: |e, sel: oh2idx(e)});
        tick();
        ent = sb.pop_front();
        chk({tag, "_push"}, 32'(push_out), 32'(ent.push));
        if (ent.push) chk({tag, "_sel"}, 32'(sel), 32'(ent.sel));
    endtask

    initial begin
        reset = 1'b0; init = 1'b0; out_afull = 1'b0;
        afull_th_in = 5'd0; aempty_th_in = 5'd0;
        empty = 4'b1111; fifo_err = 5'b0;
        tick(); tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_push", 32'(push_out), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_th", 32'({afull_th, aempty_th}), 32'd0);
        chk("rst_flags", 32'({pop, idle, active, error}), 32'd0);

        reset = 1'b1; init = 1'b1; afull_th_in = 5'd12; aempty_th_in = 5'd3;
        tick();
        chk("to_init", 32'(state), 32'd1);
        chk("init_noload", 32'(afull_th), 32'd0);
        tick();
        chk("init_stay", 32'(state), 32'd1);
        chk("afull_th", 32'(afull_th), 32'd12);
        chk("aempty_th", 32'(aempty_th), 32'd3);
        init = 1'b0; afull_th_in = 5'd7;
        tick();
        chk("to_idle", 32'(state), 32'd2);
        chk("idle_flag", 32'({idle, active, error}), 32'b100);
        chk("th_hold", 32'(afull_th), 32'd12);

        empty = 4'b0000;
        step(4'b0000, "idle_nopop");
        chk("to_active", 32'({state, active}), 32'({3'd3, 1'b1}));
        for (int r = 0; r < 2; r++) begin
            step(4'b0001, "rr0");
            step(4'b0010, "rr1");
            step(4'b0100, "rr2");
            step(4'b1000, "rr3");
        end

        step(4'b0001, "ptr1");
        empty = 4'b1010;
        step(4'b0100, "skip_a");
        step(4'b0001, "skip_b");
        step(4'b0100, "skip_c");
        step(4'b0001, "skip_d");

        empty = 4'b0000;
        step(4'b0010, "pre_afull");
        out_afull = 1'b1;
        step(4'b0000, "afull_a");
        step(4'b0000, "afull_b");
        out_afull = 1'b0;
        step(4'b0100, "resume_a");
        step(4'b1000, "resume_b");

        step(4'b0001, "pre_init");
        init = 1'b1;
        step(4'b0010, "leave_active");
        chk("reinit_state", 32'(state), 32'd1);
        init = 1'b0;
        tick();
        chk("reinit_idle", 32'(state), 32'd2);
        chk("reinit_th", 32'(afull_th), 32'd12);
        step(4'b0000, "reidle_nopop");
        empty = 4'b1111;
        step(4'b0000, "drain");
        chk("back_idle", 32'(state), 32'd2);

        empty = 4'b0000;
        step(4'b0000, "idle_go");
        step(4'b0100, "pre_err");
        empty = 4'b1111; fifo_err = 5'b10000;
        step(4'b0000, "err_entry");
        chk("err_state", 32'({state, error, active}), 32'({3'd4, 1'b1, 1'b0}));
        fifo_err = 5'b0; empty = 4'b0000;
        step(4'b0000, "err_hold_a");
        step(4'b0000, "err_hold_b");
        chk("err_persist", 32'(state), 32'd4);
        reset = 1'b0;
        tick();
        chk("err_reset", 32'({state, error}), 32'd0);
        chk("err_reset_th", 32'(afull_th), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
